multicycle_controller: RTL and testbench

- Moore FSM that sequences the multi-cycle MIPS datapath: single shared memory port, one ALU reused for PC increment, address calculation and execution.
- Instruction execution is split into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps.
- Memory access uses a ready handshake, so the datapath tolerates multi-cycle memory.
- Replaces the purely combinational decoder in the multi-cycle build. ALU op encoding is unchanged.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings for the multi-cycle and pipelined builds
//
// Purpose: opcode/funct codes, ALU op codes, controller state encodings and
// datapath mux select constants shared by the controller and the ALU decoder.
// Ports: none (package).

package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU op decode
//
// Purpose: combinational funct decode; unknown funct yields ADD with a flag.
// Ports:
//   funct   in  6  IR[5:0]
//   alu_op  out 4  ALU operation code
//   unknown out 1  funct is not a supported R-type operation

module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       unknown
);

    always_comb begin
        alu_op  = ALU_ADD;
        unknown = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLL:  alu_op = ALU_SLL;
            FN_SRL:  alu_op = ALU_SRL;
            FN_SLT:  alu_op = ALU_SLT;
            default: unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multi-cycle MIPS datapath
//
// Purpose: drives memory, register file, PC and ALU controls through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a mem_ready handshake, and
// counts retired instructions.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   opcode, funct            instruction fields from IR
//   zero                     ALU zero flag
//   mem_ready                memory completes the current access this cycle
//   mem_read, mem_write      memory strobes
//   i_or_d                   memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write       IR / PC load enables
//   pc_source                PC input select
//   alu_src_a, alu_src_b     ALU operand selects
//   alu_op                   ALU operation
//   reg_dst, mem_to_reg      register write address / data selects
//   reg_write                register file write enable
//   state                    current state (debug)
//   illegal                  unsupported opcode/funct seen in DECODE
//   retired                  completed-instruction count

module multicycle_controller
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           next_state;
    logic             retire;
    logic [CNT_W-1:0] retired_q;
    logic [3:0]       funct_op;
    logic             funct_unknown;

    alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_op  (funct_op),
        .unknown (funct_unknown)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= next_state;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by rst directly so strobes drop the moment reset
    // rises, including FETCH's mem_read once the state has been cleared.
    always_comb begin
        next_state = state_q;
        retire     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    pc_source = PC_SRC_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) next_state = S_DECODE;
                end
                S_DECODE: begin
                    // Branch target is computed here so BRANCH only compares.
                    alu_src_b = SRC_B_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW: next_state = S_MEM_ADDR;
                        OP_RTYPE: begin
                            next_state = S_R_EXEC;
                            illegal    = funct_unknown;
                        end
                        OP_BEQ:  next_state = S_BRANCH;
                        OP_J:    next_state = S_JUMP;
                        OP_ADDI: next_state = S_ADDI_EXEC;
                        default: begin
                            // Treated as a NOP: not counted as retired.
                            illegal    = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) next_state = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = funct_op;
                    next_state = S_R_WB;
                end
                S_R_WB: begin
                    // ALU op held so ALUOut's source stays consistent.
                    alu_src_a  = 1'b1;
                    alu_op     = funct_op;
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_source  = PC_SRC_ALUOUT;
                    pc_write   = zero;
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = PC_SRC_JUMP;
                    pc_write   = 1'b1;
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller

module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .state      (state),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        step();
        step();
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_alu_src_b", 32'(alu_src_b), 32'd0);
        check("rst_retired", retired, 32'd0);

        // LW with mem_ready high: 0,1,2,3,4,0
        #2;
        rst       = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b100011;
        #1;
        check("lw_fetch_state", 32'(state), 32'd0);
        check("lw_fetch_mem_read", 32'(mem_read), 32'd1);
        check("lw_fetch_ir_write", 32'(ir_write), 32'd1);
        check("lw_fetch_src_b", 32'(alu_src_b), 32'd1);
        step(); #1;
        check("lw_decode_state", 32'(state), 32'd1);
        check("lw_decode_src_b", 32'(alu_src_b), 32'd3);
        check("lw_decode_illegal", 32'(illegal), 32'd0);
        step(); #1;
        check("lw_addr_state", 32'(state), 32'd2);
        check("lw_addr_src", {30'd0, alu_src_a, 1'b0} | 32'(alu_src_b), 32'd2 | 32'd2);
        check("lw_addr_reg_write", 32'(reg_write), 32'd0);
        step(); #1;
        check("lw_rd_state", 32'(state), 32'd3);
        check("lw_rd_strobes", {29'd0, mem_read, i_or_d, mem_write}, {29'd0, 3'b110});
        step(); #1;
        check("lw_wb_state", 32'(state), 32'd4);
        check("lw_wb_ctl", {29'd0, reg_write, mem_to_reg, reg_dst}, {29'd0, 3'b110});
        check("lw_wb_retired", retired, 32'd0);
        mem_ready = 1'b0;
        step(); #1;
        check("lw_done_state", 32'(state), 32'd0);
        check("lw_done_retired", retired, 32'd1);

        // FETCH held by mem_ready low for 3 cycles
        for (int i = 0; i < 3; i++) begin
            check("wait_mem_read", 32'(mem_read), 32'd1);
            check("wait_ir_pc", {30'd0, ir_write, pc_write}, 32'd0);
            step(); #1;
            check("wait_state", 32'(state), 32'd0);
        end
        mem_ready = 1'b1;
        opcode    = 6'b000100;
        zero      = 1'b1;
        #1;
        check("wait_release_ir_pc", {30'd0, ir_write, pc_write}, 32'd3);

        // BEQ taken
        step(); #1;
        check("beq1_decode", 32'(state), 32'd1);
        step(); #1;
        check("beq1_state", 32'(state), 32'd8);
        check("beq1_pc_write", 32'(pc_write), 32'd1);
        check("beq1_pc_source", 32'(pc_source), 32'd1);
        check("beq1_alu_op", 32'(alu_op), 32'd1);
        step(); #1;
        check("beq1_done", {28'd0, state}, 32'd0);
        check("beq1_retired", retired, 32'd2);

        // BEQ not taken
        zero = 1'b0;
        step(); step(); #1;
        check("beq0_state", 32'(state), 32'd8);
        check("beq0_pc_write", 32'(pc_write), 32'd0);
        step(); #1;
        check("beq0_retired", retired, 32'd3);

        // R-type SLT
        opcode = 6'b000000;
        funct  = 6'b101010;
        step(); #1;
        check("slt_decode_illegal", 32'(illegal), 32'd0);
        step(); #1;
        check("slt_exec_state", 32'(state), 32'd6);
        check("slt_exec_alu_op", 32'(alu_op), 32'd6);
        step(); #1;
        check("slt_wb_state", 32'(state), 32'd7);
        check("slt_wb_alu_op", 32'(alu_op), 32'd6);
        check("slt_wb_ctl", {30'd0, reg_write, reg_dst}, 32'd3);
        step(); #1;
        check("slt_retired", retired, 32'd4);

        // R-type with unknown funct: illegal pulse, executes ADD, retires
        funct = 6'b111111;
        step(); #1;
        check("badfn_decode_illegal", 32'(illegal), 32'd1);
        step(); #1;
        check("badfn_exec_state", 32'(state), 32'd6);
        check("badfn_exec_alu_op", 32'(alu_op), 32'd0);
        check("badfn_exec_illegal", 32'(illegal), 32'd0);
        step(); step(); #1;
        check("badfn_retired", retired, 32'd5);

        // Unsupported opcode
        opcode = 6'b111111;
        step(); #1;
        check("badop_decode_state", 32'(state), 32'd1);
        check("badop_illegal", 32'(illegal), 32'd1);
        check("badop_writes", {30'd0, reg_write, mem_write}, 32'd0);
        step(); #1;
        check("badop_next_state", 32'(state), 32'd0);
        check("badop_retired", retired, 32'd5);

        // Jump
        opcode = 6'b000010;
        step(); step(); #1;
        check("j_state", 32'(state), 32'd9);
        check("j_pc", {29'd0, pc_write, pc_source}, {29'd0, 3'b110});
        step(); #1;
        check("j_retired", retired, 32'd6);

        // ADDI
        opcode = 6'b001000;
        step(); step(); #1;
        check("addi_exec_state", 32'(state), 32'd10);
        check("addi_exec_src_b", 32'(alu_src_b), 32'd2);
        step(); #1;
        check("addi_wb_ctl", {28'd0, state} << 2 | {30'd0, reg_write, reg_dst}, (32'd11 << 2) | 32'd2);
        step(); #1;
        check("addi_retired", retired, 32'd7);

        // SW, then reset during the write wait
        opcode = 6'b101011;
        step(); step(); #1;
        check("sw_addr_state", 32'(state), 32'd2);
        mem_ready = 1'b0;
        step(); #1;
        check("sw_wr_state", 32'(state), 32'd5);
        check("sw_wr_strobes", {30'd0, mem_write, mem_read}, 32'd2);
        step(); #1;
        check("sw_wr_held", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("sw_rst_mem_write", 32'(mem_write), 32'd0);
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_retired", retired, 32'd0);
        check("sw_rst_mem_read", 32'(mem_read), 32'd0);
        step();
        rst       = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000010;
        #1;
        check("post_rst_fetch", {30'd0, mem_read, ir_write}, 32'd3);
        step(); #1;
        check("post_rst_decode", 32'(state), 32'd1);
        step(); step(); #1;
        check("post_rst_retired", retired, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
